// File: rtl/digest_viewer.sv
// Holds a SHA-256 digest and pages it through a 4-digit seven-segment display,
// one 16-bit window at a time, stepped by debounced next/prev buttons.
module digest_viewer #(
   parameter int REFRESH_DIV     = 50000,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic         clock_50mhz,
   input  logic         rst,
   input  logic         digest_valid,
   input  logic [255:0] digest,
   input  logic         btn_next,
   input  logic         btn_prev,
   output logic [6:0]   sseg_seg,
   output logic         sseg_dp,
   output logic [3:0]   sseg_an,
   output logic [3:0]   window,
   output logic         captured
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW = $clog2(REFRESH_DIV + 1);
   localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] R_LAST  = RW'(REFRESH_DIV - 1);
   localparam logic [6:0]    DASH    = 7'b0111111;

   typedef enum logic {S_EMPTY, S_SHOW} state_t;

   state_t          state_q, state_d;
   logic [255:0]    held_q, held_d;
   logic [3:0]      win_q, win_d;
   logic            dvp_q, dvp_d;
   logic [1:0]      meta_q, meta_d;
   logic [1:0]      sync_q, sync_d;
   logic [1:0]      db_q, db_d;
   logic [1:0][CW-1:0] bcnt_q, bcnt_d;
   logic [RW-1:0]   rcnt_q, rcnt_d;
   logic [1:0]      digit_q, digit_d;
   logic [1:0]      press;
   logic [7:0]      base;
   logic [15:0]     half;
   logic [3:0]      nib;
   logic [6:0]      hex;

   always_ff @(posedge clock_50mhz or negedge rst) begin
      if (!rst) begin
         state_q <= S_EMPTY;
         held_q  <= '0;
         win_q   <= '0;
         dvp_q   <= 1'b0;
         meta_q  <= '0;
         sync_q  <= '0;
         db_q    <= '0;
         bcnt_q  <= '0;
         rcnt_q  <= '0;
         digit_q <= '0;
      end else begin
         state_q <= state_d;
         held_q  <= held_d;
         win_q   <= win_d;
         dvp_q   <= dvp_d;
         meta_q  <= meta_d;
         sync_q  <= sync_d;
         db_q    <= db_d;
         bcnt_q  <= bcnt_d;
         rcnt_q  <= rcnt_d;
         digit_q <= digit_d;
      end
   end

   // bit 0 = next, bit 1 = prev
   always_comb begin
      meta_d = {btn_prev, btn_next};
      sync_d = meta_q;
      db_d   = db_q;
      bcnt_d = bcnt_q;
      press  = '0;
      for (int i = 0; i < 2; i++) begin
         if (sync_q[i] == db_q[i]) begin
            bcnt_d[i] = '0;
         end else if (bcnt_q[i] == DB_LAST) begin
            bcnt_d[i] = '0;
            db_d[i]   = sync_q[i];
            press[i]  = sync_q[i];
         end else begin
            bcnt_d[i] = bcnt_q[i] + 1'b1;
         end
      end
   end

   always_comb begin
      state_d = state_q;
      held_d  = held_q;
      win_d   = win_q;
      dvp_d   = digest_valid;
      unique case (state_q)
         S_EMPTY: begin
            if (digest_valid) begin
               held_d  = digest;
               win_d   = '0;
               state_d = S_SHOW;
            end
         end
         S_SHOW: begin
            // a recapture wins over any coincident press
            if (digest_valid && !dvp_q) begin
               held_d = digest;
               win_d  = '0;
            end else if (press[0] && !press[1]) begin
               win_d = win_q + 4'd1;
            end else if (press[1] && !press[0]) begin
               win_d = win_q - 4'd1;
            end
         end
         default: state_d = S_EMPTY;
      endcase
   end

   always_comb begin
      rcnt_d  = rcnt_q + 1'b1;
      digit_d = digit_q;
      if (rcnt_q == R_LAST) begin
         rcnt_d  = '0;
         digit_d = digit_q + 2'd1;
      end
   end

   always_comb begin
      base = 8'd255 - {win_q, 4'h0};
      half = held_q[base -: 16];
      nib  = half[{digit_q, 2'b00} +: 4];
      unique case (nib)
         4'h0: hex = 7'b1000000;
         4'h1: hex = 7'b1111001;
         4'h2: hex = 7'b0100100;
         4'h3: hex = 7'b0110000;
         4'h4: hex = 7'b0011001;
         4'h5: hex = 7'b0010010;
         4'h6: hex = 7'b0000010;
         4'h7: hex = 7'b1111000;
         4'h8: hex = 7'b0000000;
         4'h9: hex = 7'b0010000;
         4'hA: hex = 7'b0001000;
         4'hB: hex = 7'b0000011;
         4'hC: hex = 7'b1000110;
         4'hD: hex = 7'b0100001;
         4'hE: hex = 7'b0000110;
         default: hex = 7'b0001110;
      endcase
   end

   assign sseg_an  = ~(4'b0001 << digit_q);
   assign sseg_seg = (state_q == S_SHOW) ? hex : DASH;
   assign sseg_dp  = !((state_q == S_SHOW) && (digit_q == 2'd3)
                       && (win_q == 4'd0));
   assign window   = win_q;
   assign captured = (state_q == S_SHOW);

endmodule
